// File: rtl/router_pkg.sv
// Shared defaults and types for the router synchroniser slice.
// Latency: n/a (constants and typedefs only).
// Backpressure: n/a.
package router_pkg;

  localparam int ROUTER_NUM_PORTS = 3;
  localparam int ROUTER_ADDR_W    = 2;
  localparam int ROUTER_TIMEOUT   = 30;
  localparam int ROUTER_STAT_W    = 8;

  // One bit per output channel at the default port count.
  typedef logic [ROUTER_NUM_PORTS-1:0] port_mask_t;

endpackage

// File: rtl/router_sync_wdog.sv
// Per-port stall watchdog: pulses soft_reset after TIMEOUT consecutive stalled cycles.
// Latency: pulse is registered, visible the cycle after the TIMEOUT-th stalled cycle.
// Backpressure: none; a non-stalled cycle (read or empty) restarts the count.
// Optional timeout-event counter when ROUTER_SYNC_STATS_EN is defined.
module router_sync_wdog
  import router_pkg::*;
#(
  parameter int TIMEOUT = ROUTER_TIMEOUT
`ifdef ROUTER_SYNC_STATS_EN
  , parameter int STAT_W = ROUTER_STAT_W
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  output logic              soft_reset
`ifdef ROUTER_SYNC_STATS_EN
  , input  logic              stat_clr
  , output logic [STAT_W-1:0] stat_cnt
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Count consecutive stalled cycles; fire a single-cycle pulse and restart at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (stall) begin
      if (cnt == LAST) begin
        cnt        <= '0;
        soft_reset <= 1'b1;
      end else begin
        cnt        <= cnt + 1'b1;
        soft_reset <= 1'b0;
      end
    end else begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end
  end

`ifdef ROUTER_SYNC_STATS_EN
  // Saturating count of visible soft_reset pulses; clear has priority over a pulse.
  always_ff @(posedge clock) begin
    if (reset || stat_clr) begin
      stat_cnt <= '0;
    end else if (soft_reset && (stat_cnt != '1)) begin
      stat_cnt <= stat_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/router_sync_ctrl.sv
// Router synchroniser: latches destination, steers one-hot FIFO writes, muxes full, runs watchdogs.
// Latency: write_enb/fifo_full/vld_out combinational; addr_err and soft_reset registered.
// Backpressure: fifo_full of the selected FIFO stalls the FSM; bad destinations drop, never stall.
// Optional macro ROUTER_SYNC_STATS_EN adds stat_clr / stat_timeouts per-port timeout counters.
module router_sync_ctrl
  import router_pkg::*;
#(
  parameter int NUM_PORTS = ROUTER_NUM_PORTS,
  parameter int ADDR_W    = ROUTER_ADDR_W,
  parameter int TIMEOUT   = ROUTER_TIMEOUT
`ifdef ROUTER_SYNC_STATS_EN
  , parameter int STAT_W  = ROUTER_STAT_W
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 detect_add,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 write_enb_reg,
  input  logic [NUM_PORTS-1:0] read_enb,
  input  logic [NUM_PORTS-1:0] empty,
  input  logic [NUM_PORTS-1:0] full,
  output logic [NUM_PORTS-1:0] vld_out,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 fifo_full,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 addr_err
`ifdef ROUTER_SYNC_STATS_EN
  , input  logic                        stat_clr
  , output logic [NUM_PORTS*STAT_W-1:0] stat_timeouts
`endif
);

  // One extra bit so NUM_PORTS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] NP = (ADDR_W + 1)'(NUM_PORTS);

  logic [ADDR_W-1:0] dest;

  assign vld_out = ~empty;

  // Destination register and range check, updated only on the header cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      dest     <= '0;
      addr_err <= 1'b0;
    end else if (detect_add) begin
      dest     <= data_in;
      addr_err <= ({1'b0, data_in} >= NP);
    end
  end

  // Decode the held destination into a one-hot write strobe and select its full flag.
  // Using the registered dest means a same-cycle header still writes to the old port.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (dest == ADDR_W'(i)) begin
        write_enb[i] = write_enb_reg & ~addr_err;
        fifo_full    = full[i] & ~addr_err;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_wdog
      router_sync_wdog #(
        .TIMEOUT (TIMEOUT)
`ifdef ROUTER_SYNC_STATS_EN
        , .STAT_W (STAT_W)
`endif
      ) u_wdog (
        .clock      (clock),
        .reset      (reset),
        .stall      (vld_out[g] & ~read_enb[g]),
        .soft_reset (soft_reset[g])
`ifdef ROUTER_SYNC_STATS_EN
        , .stat_clr (stat_clr)
        , .stat_cnt (stat_timeouts[g*STAT_W +: STAT_W])
`endif
      );
    end
  endgenerate

endmodule
